// File: rtl/micro_sequencer_pkg.sv
// Shared encodings for the control-store sequencer: COND field values, FSM states
// and PSR flag bit positions on the packed {C,V,Z,N} flag bus.
package micro_sequencer_pkg;

    localparam logic [2:0] COND_INC    = 3'b000;
    localparam logic [2:0] COND_N      = 3'b001;
    localparam logic [2:0] COND_Z      = 3'b010;
    localparam logic [2:0] COND_V      = 3'b011;
    localparam logic [2:0] COND_C      = 3'b100;
    localparam logic [2:0] COND_IR13   = 3'b101;
    localparam logic [2:0] COND_JUMP   = 3'b110;
    localparam logic [2:0] COND_DECODE = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_WAIT = 2'b10,
        S_HALT = 2'b11
    } useqState_t;

    localparam int PSR_C = 3;
    localparam int PSR_V = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

endpackage

// File: rtl/micro_sequencer_cond_mux.sv
// Branch-condition evaluator: decides from COND, the PSR flags and IR[13] whether
// the next micro-address is non-sequential (jump or decode).
module micro_sequencer_cond_mux
    import micro_sequencer_pkg::*;
#(
    parameter int PSR_W = 4
)(
    input  logic [2:0]       cond,
    input  logic [PSR_W-1:0] psr,
    input  logic             irBit13,
    output logic             takeJump
);

    always_comb begin
        takeJump = 1'b0;
        case (cond)
            COND_INC:    takeJump = 1'b0;
            COND_N:      takeJump = psr[PSR_N];
            COND_Z:      takeJump = psr[PSR_Z];
            COND_V:      takeJump = psr[PSR_V];
            COND_C:      takeJump = psr[PSR_C];
            COND_IR13:   takeJump = irBit13;
            // decode also counts as a non-sequential transfer
            COND_JUMP,
            COND_DECODE: takeJump = 1'b1;
            default:     takeJump = 1'b0;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Control-store address sequencer: IDLE/RUN/WAIT/HALT FSM plus next-address select
// (increment, conditional/unconditional jump, opcode decode).
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int                   USEQ_ADDR   = 11,
    parameter int                   USEQ_PSR    = 4,
    parameter logic [USEQ_ADDR-1:0] USEQ_RSTADR = '0
)(
    input  logic                 USEQ_CLOCK_50,
    input  logic                 USEQ_ResetInLow_In,
    input  logic [USEQ_PSR-1:0]  USEQ_Psr_InBus,
    input  logic [2:0]           USEQ_Cond_InBus,
    input  logic [USEQ_ADDR-1:0] USEQ_JumpAddr_InBus,
    input  logic [USEQ_ADDR-1:0] USEQ_DecodeAddr_InBus,
    input  logic                 USEQ_IrBit13_In,
    input  logic                 USEQ_MemAccess_In,
    input  logic                 USEQ_MemReady_In,
    input  logic                 USEQ_Halt_In,
    output logic [USEQ_ADDR-1:0] USEQ_Address_OutBus,
    output logic                 USEQ_Valid_Out,
    output logic                 USEQ_Taken_Out,
    output logic                 USEQ_Busy_Out
);

    localparam logic [USEQ_ADDR-1:0] ADDR_ONE = USEQ_ADDR'(1);

    useqState_t           state;
    logic                 takeJump;
    logic [USEQ_ADDR-1:0] nextAddr;
    logic                 nextTaken;

    micro_sequencer_cond_mux #(
        .PSR_W (USEQ_PSR)
    ) uCondMux (
        .cond     (USEQ_Cond_InBus),
        .psr      (USEQ_Psr_InBus),
        .irBit13  (USEQ_IrBit13_In),
        .takeJump (takeJump)
    );

    // Increment wraps naturally at the address width.
    always_comb begin
        nextAddr  = USEQ_Address_OutBus + ADDR_ONE;
        nextTaken = 1'b0;
        if (USEQ_Cond_InBus == COND_DECODE) begin
            nextAddr  = USEQ_DecodeAddr_InBus;
            nextTaken = 1'b1;
        end else if (takeJump) begin
            nextAddr  = USEQ_JumpAddr_InBus;
            nextTaken = 1'b1;
        end
    end

    always_ff @(posedge USEQ_CLOCK_50 or negedge USEQ_ResetInLow_In) begin
        if (!USEQ_ResetInLow_In) begin
            state               <= S_IDLE;
            USEQ_Address_OutBus <= USEQ_RSTADR;
            USEQ_Valid_Out      <= 1'b0;
            USEQ_Taken_Out      <= 1'b0;
            USEQ_Busy_Out       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state          <= S_RUN;
                    USEQ_Valid_Out <= 1'b1;
                    USEQ_Busy_Out  <= 1'b0;
                end
                S_RUN: begin
                    if (USEQ_Halt_In) begin
                        state          <= S_HALT;
                        USEQ_Valid_Out <= 1'b0;
                        USEQ_Busy_Out  <= 1'b0;
                    end else if (USEQ_MemAccess_In && !USEQ_MemReady_In) begin
                        state         <= S_WAIT;
                        USEQ_Busy_Out <= 1'b1;
                    end else begin
                        USEQ_Address_OutBus <= nextAddr;
                        USEQ_Taken_Out      <= nextTaken;
                    end
                end
                // Halt requests are deliberately not sampled while stalled.
                S_WAIT: begin
                    if (USEQ_MemReady_In) begin
                        state               <= S_RUN;
                        USEQ_Busy_Out       <= 1'b0;
                        USEQ_Address_OutBus <= nextAddr;
                        USEQ_Taken_Out      <= nextTaken;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state          <= S_IDLE;
                    USEQ_Valid_Out <= 1'b0;
                    USEQ_Busy_Out  <= 1'b0;
                end
            endcase
        end
    end

endmodule
